// File: rtl/mux4_arbiter_if.sv
// mux4_arbiter_if: request/grant/select bundle between the four requesters
// and the round-robin arbiter that steers the shared 4:1 datapath mux.
//   master : requester side, drives req and observes the arbiter outputs
//   slave  : arbiter side, samples req and drives grant/selects/status
interface mux4_arbiter_if;
    logic [3:0] req;      // req[n] high: requester n wants the mux
    logic [3:0] grant;    // one-hot grant, zero when idle
    logic       s0;       // mux select LSB
    logic       s1;       // mux select MSB
    logic       busy;     // any grant active
    logic       preempt;  // grant ended by the hold limit (one-cycle pulse)

    modport master (
        output req,
        input  grant,
        input  s0,
        input  s1,
        input  busy,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output s0,
        output s1,
        output busy,
        output preempt
    );
endinterface : mux4_arbiter_if

// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin arbiter and select sequencer for the 4:1
// datapath mux. One requester owns the mux at a time; the grant is held
// until that requester drops its request, then the pointer moves one past
// the owner and arbitration restarts in the same cycle (no dead cycle).
//
// Optional feature: define MUX4_ARB_HOLD_LIMIT_EN to build the hold counter.
// With it, a grant that has lasted MAX_HOLD cycles is forcibly ended and
// preempt pulses for one cycle alongside the next grant. Without it, grants
// last until release and preempt is constant 0.
//
// All outputs are registered; reset is synchronous and active-high.
module mux4_arbiter #(
    parameter int MAX_HOLD = 8     // legal range 2..255
) (
    input  logic           clk,
    input  logic           rst,
    mux4_arbiter_if.slave  bus
);

    // Two-state controller encoding.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // An out-of-range MAX_HOLD elaborates this marker scope, which makes the
    // misconfiguration visible in the elaborated hierarchy.
    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_max_hold_out_of_range
    end

    // Pick the first set request in priority order base, base+1, ... mod 4.
    // Only meaningful when vec is nonzero; returns base otherwise.
    function automatic logic [1:0] rr_pick(input logic [3:0] vec,
                                           input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        logic [1:0] win;
        win   = base;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && vec[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

    // One-hot decode of a 2-bit mux index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] vec;
        case (idx)
            2'd0:    vec = 4'b0001;
            2'd1:    vec = 4'b0010;
            2'd2:    vec = 4'b0100;
            2'd3:    vec = 4'b1000;
            default: vec = 4'b0000;
        endcase
        return vec;
    endfunction

    // Architectural state.
    logic [0:0] state_r;
    logic [1:0] ptr_r;       // highest-priority index for the next arbitration
    logic [1:0] cur_r;       // current (or last) owner of the mux

    // Registered outputs.
    logic [3:0] grant_r;
    logic [1:0] sel_r;
    logic       busy_r;
    logic       preempt_r;

    // Next-state values.
    logic [0:0] state_s;
    logic [1:0] ptr_s;
    logic [1:0] cur_s;
    logic [3:0] grant_s;
    logic [1:0] sel_s;
    logic       busy_s;
    logic       preempt_s;

    // Grant-ending conditions.
    logic       granted_s;   // controller currently in GRANT
    logic       release_s;   // owner dropped its request
    logic       limit_s;     // owner hit the hold limit while still requesting
    logic       rearb_s;     // grant ends this edge for either reason

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LIMIT_C = 8'(MAX_HOLD);

    logic [7:0] hcnt_r;      // cycles the current grant has been held
    logic [7:0] hcnt_s;

    // Hold limit reached: owner is still requesting but must yield.
    always_comb begin
        if ((state_r == ST_GRANT) && bus.req[cur_r] && (hcnt_r == HOLD_LIMIT_C)) begin
            limit_s = 1'b1;
        end else begin
            limit_s = 1'b0;
        end
    end
`else
    // Hold limit compiled out: grants only end on release.
    always_comb begin
        limit_s = 1'b0;
    end
`endif

    // Classify the current cycle's grant condition.
    always_comb begin
        granted_s = (state_r == ST_GRANT);
        if (granted_s && !bus.req[cur_r]) begin
            release_s = 1'b1;
        end else begin
            release_s = 1'b0;
        end
        rearb_s = release_s | limit_s;
    end

    // Controller next state: arbitrate from IDLE, or re-arbitrate when the
    // current grant ends, using the pointer advanced past the old owner.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        cur_s     = cur_r;
        preempt_s = 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        hcnt_s    = hcnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_s = ST_GRANT;
                    cur_s   = rr_pick(bus.req, ptr_r);
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                    hcnt_s  = 8'd1;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (rearb_s) begin
                    ptr_s     = cur_r + 2'd1;
                    preempt_s = limit_s;
                    if (bus.req != 4'b0000) begin
                        state_s = ST_GRANT;
                        cur_s   = rr_pick(bus.req, cur_r + 2'd1);
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                        hcnt_s  = 8'd1;
`endif
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_GRANT;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                    hcnt_s  = hcnt_r + 8'd1;
`endif
                end
            end
            default: begin
                state_s = ST_IDLE;
                ptr_s   = 2'd0;
                cur_s   = 2'd0;
            end
        endcase
    end

    // Output decode from next state; selects hold the last owner in IDLE so
    // the mux output stays stable.
    always_comb begin
        if (state_s == ST_GRANT) begin
            grant_s = onehot4(cur_s);
            sel_s   = cur_s;
            busy_s  = 1'b1;
        end else begin
            grant_s = 4'b0000;
            sel_s   = sel_r;
            busy_s  = 1'b0;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 2'd0;
            cur_r     <= 2'd0;
            grant_r   <= 4'b0000;
            sel_r     <= 2'b00;
            busy_r    <= 1'b0;
            preempt_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            cur_r     <= cur_s;
            grant_r   <= grant_s;
            sel_r     <= sel_s;
            busy_r    <= busy_s;
            preempt_r <= preempt_s;
        end
    end

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    // Hold counter: restarts at 1 on each new grant, counts held cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_r <= 8'd0;
        end else begin
            hcnt_r <= hcnt_s;
        end
    end
`endif

    assign bus.grant   = grant_r;
    assign bus.s1      = sel_r[1];
    assign bus.s0      = sel_r[0];
    assign bus.busy    = busy_r;
    assign bus.preempt = preempt_r;

endmodule : mux4_arbiter

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: directed self-checking bench for mux4_arbiter.
// Each check compares the output tuple {grant, s1, s0, busy, preempt}
// against a hand-computed expected value.
module tb_mux4_arbiter;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    mux4_arbiter_if bus ();

    mux4_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {grant[3:0], s1, s0, busy, preempt}.
    function automatic logic [7:0] obs();
        return {bus.grant, bus.s1, bus.s0, bus.busy, bus.preempt};
    endfunction

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clean restart so every scenario begins with ptr=0, cur=0.
    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] o;
        rst     = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            o = obs();
            vectors++;
            if (o !== 8'b0000_00_0_0) begin
                $display("FAIL reset_hold[%0d]: got %b want %b", i, o, 8'b0000_00_0_0);
                errors++;
            end
        end
        rst = 1'b0;
        step();
        o = obs();
        vectors++;
        if (o !== 8'b0001_00_1_0) begin
            $display("FAIL reset_first_grant: got %b want %b", o, 8'b0001_00_1_0);
            errors++;
        end
    endtask

    task automatic test_single();
        logic [7:0] o;
        do_reset();
        bus.req = 4'b0100;
        step();
        o = obs();
        vectors++;
        if (o !== 8'b0100_10_1_0) begin
            $display("FAIL single_grant: got %b want %b", o, 8'b0100_10_1_0);
            errors++;
        end
        step();
        o = obs();
        vectors++;
        if (o !== 8'b0100_10_1_0) begin
            $display("FAIL single_hold: got %b want %b", o, 8'b0100_10_1_0);
            errors++;
        end
        bus.req = 4'b0000;
        step();
        o = obs();
        vectors++;
        if (o !== 8'b0000_10_0_0) begin
            $display("FAIL single_release_sel_kept: got %b want %b", o, 8'b0000_10_0_0);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] o;
        logic [3:0] seq_g [4];
        logic [1:0] seq_s [4];
        logic [3:0] held;
        seq_g[0] = 4'b0010; seq_s[0] = 2'b01;
        seq_g[1] = 4'b0100; seq_s[1] = 2'b10;
        seq_g[2] = 4'b1000; seq_s[2] = 2'b11;
        seq_g[3] = 4'b0001; seq_s[3] = 2'b00;
        do_reset();
        bus.req = 4'b1111;
        step();
        held = 4'b0001;
        o = obs();
        vectors++;
        if (o !== 8'b0001_00_1_0) begin
            $display("FAIL rr_first: got %b want %b", o, 8'b0001_00_1_0);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            step();
            o = obs();
            vectors++;
            if (o[7:4] !== held) begin
                $display("FAIL rr_hold[%0d]: got grant %b want %b", i, o[7:4], held);
                errors++;
            end
            bus.req = 4'b1111 & ~held;
            step();
            bus.req = 4'b1111;
            o = obs();
            vectors++;
            if (o !== {seq_g[i], seq_s[i], 1'b1, 1'b0}) begin
                $display("FAIL rr_next[%0d]: got %b want %b", i, o, {seq_g[i], seq_s[i], 1'b1, 1'b0});
                errors++;
            end
            held = seq_g[i];
        end
    endtask

    task automatic test_pointer_skip();
        logic [7:0] o;
        do_reset();
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0000;
        step();
        o = obs();
        vectors++;
        if (o !== 8'b0000_00_0_0) begin
            $display("FAIL ptr_idle: got %b want %b", o, 8'b0000_00_0_0);
            errors++;
        end
        bus.req = 4'b1001;
        step();
        o = obs();
        vectors++;
        if (o !== 8'b1000_11_1_0) begin
            $display("FAIL ptr_skip: got %b want %b", o, 8'b1000_11_1_0);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] o;
        do_reset();
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0100;  // owner drops while requester 2 rises
        step();
        o = obs();
        vectors++;
        if (o !== 8'b0100_10_1_0) begin
            $display("FAIL b2b_same_cycle: got %b want %b", o, 8'b0100_10_1_0);
            errors++;
        end
        bus.req = 4'b1111;  // others must not disturb the active grant
        step();
        step();
        o = obs();
        vectors++;
        if (o !== 8'b0100_10_1_0) begin
            $display("FAIL b2b_no_disturb: got %b want %b", o, 8'b0100_10_1_0);
            errors++;
        end
        bus.req = 4'b1011;  // release 2: ptr=3, index 3 wins
        step();
        o = obs();
        vectors++;
        if (o !== 8'b1000_11_1_0) begin
            $display("FAIL b2b_wrap: got %b want %b", o, 8'b1000_11_1_0);
            errors++;
        end
    endtask

    task automatic test_hold_limit();
        logic [7:0] o;
        do_reset();
        bus.req = 4'b0011;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        begin
            logic [7:0] exp_v [13];
            // 4 cycles of 0001, preempt to 0010 for 4 cycles, preempt back...
            for (int i = 0; i < 13; i++) begin
                if (i < 4)       exp_v[i] = {4'b0001, 2'b00, 1'b1, 1'b0};
                else if (i < 8)  exp_v[i] = {4'b0010, 2'b01, 1'b1, (i == 4) ? 1'b1 : 1'b0};
                else if (i < 12) exp_v[i] = {4'b0001, 2'b00, 1'b1, (i == 8) ? 1'b1 : 1'b0};
                else             exp_v[i] = {4'b0010, 2'b01, 1'b1, 1'b1};
            end
            for (int i = 0; i < 13; i++) begin
                step();
                o = obs();
                vectors++;
                if (o !== exp_v[i]) begin
                    $display("FAIL hold_limit[%0d]: got %b want %b", i, o, exp_v[i]);
                    errors++;
                end
            end
        end
`else
        for (int i = 0; i < 12; i++) begin
            step();
            o = obs();
            vectors++;
            if (o !== 8'b0001_00_1_0) begin
                $display("FAIL hold_unlimited[%0d]: got %b want %b", i, o, 8'b0001_00_1_0);
                errors++;
            end
        end
`endif
    endtask

    task automatic test_reset_mid_grant();
        logic [7:0] o;
        do_reset();
        bus.req = 4'b0100;
        step();
        o = obs();
        vectors++;
        if (o !== 8'b0100_10_1_0) begin
            $display("FAIL midrst_pre: got %b want %b", o, 8'b0100_10_1_0);
            errors++;
        end
        bus.req = 4'b0110;
        rst     = 1'b1;
        step();
        o = obs();
        vectors++;
        if (o !== 8'b0000_00_0_0) begin
            $display("FAIL midrst_forced: got %b want %b", o, 8'b0000_00_0_0);
            errors++;
        end
        rst = 1'b0;
        step();
        o = obs();
        vectors++;
        if (o !== 8'b0010_01_1_0) begin
            $display("FAIL midrst_resume: got %b want %b", o, 8'b0010_01_1_0);
            errors++;
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.req = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_skip();
        test_back_to_back();
        test_hold_limit();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_mux4_arbiter
